// File: rtl/full_subtractor_serial_pkg.sv
// rtl/full_subtractor_serial_pkg.sv - shared constants and FSM encoding for the serial subtractor
//
// Purpose : default operand width and the three-state controller encoding,
//           imported by the interface, the top and the bench.
// Ports   : none (package).

package full_subtractor_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor_serial_if.sv
// rtl/full_subtractor_serial_if.sv - request/result bundle between requester and serial subtractor
//
// Purpose : groups the operation request (start, a, b, bin) and the result
//           side (diff, bout, busy, done) into one port.
// Ports   : master - drives start/a/b/bin, observes diff/bout/busy/done
//           slave  - the subtractor; observes the request, drives the result

interface full_subtractor_serial_if
  import full_subtractor_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done
  );

endinterface

// File: rtl/full_subtractor_serial_full_subtractor.sv
// rtl/full_subtractor_serial_full_subtractor.sv - one-bit full subtractor cell
//
// Purpose : combinational x - y - bi for a single bit.
// Ports   : x  - minuend bit       y  - subtrahend bit     bi - borrow in
//           d  - difference bit    bo - borrow out

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/full_subtractor_serial.sv
// rtl/full_subtractor_serial.sv - bit-serial a - b - bin, one bit per clock, LSB first
//
// Purpose : latches operands on an accepted start, walks them through a single
//           full-subtractor cell, then publishes diff/bout with a one-cycle done.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset
//           bus - slave side of full_subtractor_serial_if (start/a/b/bin in,
//                 diff/bout/busy/done out)

module full_subtractor_serial
  import full_subtractor_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                      clk,
  input logic                      rst,
  full_subtractor_serial_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             bit_d;
  logic             bit_bo;
  logic             last_bit_done;

  // The counter reaches WIDTH once every bit has been folded into res_q;
  // that RUN cycle only hands the result over and moves to DONE.
  assign last_bit_done = (cnt_q == CNT_W'(WIDTH));

  full_subtractor u_cell (
    .x  (x_q[0]),
    .y  (y_q[0]),
    .bi (br_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last_bit_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            x_q   <= bus.a;
            y_q   <= bus.b;
            br_q  <= bus.bin;
            res_q <= '0;
            cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (last_bit_done) begin
            diff_q <= res_q;
            bout_q <= br_q;
          end else begin
            // Result bits enter at the MSB so bit 0 ends up at res_q[0].
            x_q   <= x_q >> 1;
            y_q   <= y_q >> 1;
            res_q <= {bit_d, res_q[WIDTH-1:1]};
            br_q  <= bit_bo;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_full_subtractor_serial.sv
// tb/tb_full_subtractor_serial.sv - randomized self-checking bench for full_subtractor_serial

module tb_full_subtractor_serial;
  import full_subtractor_serial_pkg::*;

  localparam int W         = 8;
  localparam int LATENCY   = W + 1;  // accept edge to completion edge
  localparam int OP_PERIOD = W + 3;  // completion + DONE cycle + return to IDLE

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [W-1:0] last_diff;
  logic         last_bout;

  full_subtractor_serial_if #(.WIDTH(W)) fs ();

  full_subtractor_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_diff(input int av, input int bv, input int cv);
    int t;
    t = (av - bv - cv) % (1 << W);
    if (t < 0) t += (1 << W);
    return t[W-1:0];
  endfunction

  function automatic logic ref_bout(input int av, input int bv, input int cv);
    return (av < bv + cv);
  endfunction

  // One operation; restart_at >= 1 pulses a stray start at that edge after acceptance.
  task automatic run_op(input int av, input int bv, input int cv, input int restart_at);
    int k;
    logic [W-1:0] ed;
    logic eb;
    ed = ref_diff(av, bv, cv);
    eb = ref_bout(av, bv, cv);
    @(negedge clk);
    fs.start = 1'b1; fs.a = W'(av); fs.b = W'(bv); fs.bin = cv[0];
    @(posedge clk);
    #1;
    fs.start = 1'b0; fs.a = W'($urandom); fs.b = W'($urandom); fs.bin = 1'($urandom);
    @(negedge clk);
    check("busy_after_accept", fs.busy, 1);
    check("diff_held_in_run", fs.diff, last_diff);
    k = 0;
    while (k < 40) begin
      if (k == restart_at - 1) begin
        fs.start = 1'b1; fs.a = 8'h11; fs.b = 8'h22;
      end else begin
        fs.start = 1'b0;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
      if (fs.done) break;
    end
    fs.start = 1'b0;
    check("latency", k, LATENCY);
    check("diff", fs.diff, ed);
    check("bout", fs.bout, eb);
    @(negedge clk);
    check("single_done", fs.done, 0);
    check("diff_hold", fs.diff, ed);
    @(negedge clk);
    check("idle_busy", fs.busy, 0);
    last_diff = ed;
    last_bout = eb;
  endtask

  initial begin
    int k;
    int last_done;
    int last_acc;
    int cyc;
    logic prev_busy;
    logic [W-1:0] pa, pb;
    logic pc;
    logic [W-1:0] q_d[$];
    logic         q_b[$];

    n_checks = 0; n_pass = 0;
    last_diff = '0; last_bout = 1'b0;
    fs.start = 1'b0; fs.a = '0; fs.b = '0; fs.bin = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_diff", fs.diff, 0);
    check("rst_bout", fs.bout, 0);
    check("rst_busy", fs.busy, 0);
    check("rst_done", fs.done, 0);
    rst = 1'b0;

    run_op(8'h5A, 8'h3C, 0, -1);
    run_op(8'h00, 8'h01, 0, -1);
    run_op(8'h80, 8'h80, 1, -1);
    run_op(8'hFF, 8'h00, 1, -1);
    run_op(8'h33, 8'h44, 0, 3);

    // Reset in the middle of RUN.
    @(negedge clk);
    fs.start = 1'b1; fs.a = 8'h77; fs.b = 8'h12; fs.bin = 1'b0;
    @(posedge clk);
    #1 fs.start = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_diff", fs.diff, 0);
    check("midrst_bout", fs.bout, 0);
    check("midrst_busy", fs.busy, 0);
    check("midrst_done", fs.done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", fs.done, 0);
    end
    rst = 1'b0;
    last_diff = '0; last_bout = 1'b0;
    run_op(8'h10, 8'h01, 0, -1);

    // Back-to-back with start held high and fresh random operands every cycle.
    prev_busy = 1'b0; last_done = -1; last_acc = -1;
    pa = '0; pb = '0; pc = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (fs.busy && !prev_busy) begin
        if (last_acc >= 0) check("accept_period", cyc - last_acc, OP_PERIOD);
        last_acc = cyc;
        q_d.push_back(ref_diff(int'(pa), int'(pb), int'(pc)));
        q_b.push_back(ref_bout(int'(pa), int'(pb), int'(pc)));
      end
      if (fs.done) begin
        if (last_done >= 0) check("done_period", cyc - last_done, OP_PERIOD);
        last_done = cyc;
        if (q_d.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("b2b_diff", fs.diff, q_d.pop_front());
          check("b2b_bout", fs.bout, q_b.pop_front());
        end
      end
      prev_busy = fs.busy;
      pa = W'($urandom); pb = W'($urandom); pc = 1'($urandom);
      fs.a = pa; fs.b = pb; fs.bin = pc;
      fs.start = (cyc < 160);
    end
    k = q_d.size();
    check("b2b_drained", k, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
